// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller: gathers stream words into blocks, applies
// ECB/CBC-encrypt/CTR chaining around an AES engine, buffers results in a FIFO.
module aes_mode_ctrl #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int CTR_W       = 32,
  parameter int FIFO_DEPTH  = 2,
  localparam int BW         = WORD_W * BLOCK_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        mode,
  input  logic [BW-1:0]     iv_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              eng_start,
  output logic [BW-1:0]     eng_block,
  input  logic              eng_done,
  input  logic [BW-1:0]     eng_result,
  output logic              busy
);

  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] M_ECB = 2'd0;
  localparam logic [1:0] M_CBC = 2'd1;
  localparam logic [1:0] M_CTR = 2'd2;

  typedef enum logic [1:0] {COLLECT, LAUNCH, RUN} state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [BW-1:0]   in_buf_q, in_buf_d;
  logic [1:0]      mode_q, mode_d;
  logic [BW-1:0]   chain_q, chain_d;
  logic [BW-1:0]   ctr_q, ctr_d;
  logic [BW-1:0]   eng_block_q, eng_block_d;
  logic [BW-1:0]   fifo_q [FIFO_DEPTH];
  logic [BW-1:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WCW-1:0]  optr_q, optr_d;

  logic            last_w, slot, push, pop, cfg_ok;
  logic [WCW-1:0]  irev, orev;
  logic [BW-1:0]   head, push_blk;

  assign last_w    = wcnt_q == WCW'(BLOCK_WORDS - 1);
  assign slot      = cnt_q < CW'(FIFO_DEPTH);
  assign push      = (state_q == RUN) && eng_done;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid && out_ready
                   && (optr_q == WCW'(BLOCK_WORDS - 1));
  assign cfg_ok    = cfg_load && (state_q == COLLECT) && (wcnt_q == '0);
  assign irev      = WCW'(BLOCK_WORDS - 1) - wcnt_q;
  assign orev      = WCW'(BLOCK_WORDS - 1) - optr_q;
  assign head      = fifo_q[rd_q];
  assign push_blk  = (mode_q == M_CTR) ? (eng_result ^ in_buf_q) : eng_result;
  assign out_word  = out_valid ? head[int'(orev)*WORD_W +: WORD_W] : '0;
  assign in_ready  = state_q == COLLECT;
  assign busy      = state_q != COLLECT;
  assign eng_block = eng_block_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    in_buf_d    = in_buf_q;
    mode_d      = mode_q;
    chain_d     = chain_q;
    ctr_d       = ctr_q;
    eng_block_d = eng_block_q;
    fifo_d      = fifo_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    optr_d      = optr_q;
    eng_start   = 1'b0;

    if (cfg_ok) begin
      mode_d  = (mode == 2'd3) ? M_ECB : mode;
      chain_d = iv_in;
      ctr_d   = iv_in;
    end

    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          in_buf_d[int'(irev)*WORD_W +: WORD_W] = in_word;
          if (last_w) begin
            wcnt_d  = '0;
            state_d = LAUNCH;
            // Use the _d views so a same-cycle cfg_load is respected.
            case (mode_d)
              M_CBC:   eng_block_d = in_buf_d ^ chain_d;
              M_CTR:   eng_block_d = ctr_d;
              default: eng_block_d = in_buf_d;
            endcase
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      LAUNCH: begin
        if (slot) begin
          eng_start = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (eng_done) begin
          state_d      = COLLECT;
          fifo_d[wr_q] = push_blk;
          wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
          if (mode_q == M_CBC) chain_d = eng_result;
          if (mode_q == M_CTR)
            ctr_d[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase

    if (pop) begin
      optr_d = '0;
      rd_d   = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end else if (out_valid && out_ready) begin
      optr_d = optr_q + WCW'(1);
    end

    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      wcnt_q      <= '0;
      in_buf_q    <= '0;
      mode_q      <= M_ECB;
      chain_q     <= '0;
      ctr_q       <= '0;
      eng_block_q <= '0;
      fifo_q      <= '{default: '0};
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      optr_q      <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      in_buf_q    <= in_buf_d;
      mode_q      <= mode_d;
      chain_q     <= chain_d;
      ctr_q       <= ctr_d;
      eng_block_q <= eng_block_d;
      fifo_q      <= fifo_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      optr_q      <= optr_d;
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with an inverting 3-cycle mock engine.
module tb_aes_mode_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_load;
  logic [1:0]   mode;
  logic [127:0] iv_in;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         eng_start;
  logic [127:0] eng_block;
  logic         eng_done;
  logic [127:0] eng_result;
  logic         busy;

  aes_mode_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .mode       (mode),
    .iv_in      (iv_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .eng_start  (eng_start),
    .eng_block  (eng_block),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] st_blk[$];
  int           st_cyc[$];
  int           dn_cyc[$];
  logic [31:0]  ow[$];
  int           oc[$];

  logic [127:0] mk_blk;
  int           mk_cnt = 0;

  // Monitor plus mock engine: result = ~block, done 3 cycles after start.
  always @(negedge clk) begin
    if (eng_start) begin
      st_blk.push_back(eng_block);
      st_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      ow.push_back(out_word);
      oc.push_back(cyc);
    end
    eng_done = 1'b0;
    if (mk_cnt != 0) begin
      mk_cnt--;
      if (mk_cnt == 0) begin
        eng_done   = 1'b1;
        eng_result = ~mk_blk;
        dn_cyc.push_back(cyc);
      end
    end
    if (eng_start) begin
      mk_blk = eng_block;
      mk_cnt = 3;
    end
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    st_blk.delete(); st_cyc.delete(); dn_cyc.delete();
    ow.delete(); oc.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_tmo", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32]);
  endtask

  task automatic cfg(input logic [1:0] m, input logic [127:0] iv);
    mode = m; iv_in = iv; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (ow.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (ow.size() < n) check("out_tmo", ow.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input int n);
    int k = 0;
    while (st_blk.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (st_blk.size() < n) check("start_tmo", st_blk.size(), n);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] blk_out(input int k);
    return {ow[4*k], ow[4*k+1], ow[4*k+2], ow[4*k+3]};
  endfunction

  localparam logic [127:0] IV_CBC = {16{8'h01}};
  localparam logic [127:0] IV_CTR = {{12{8'hA5}}, 32'hFFFF_FFFF};

  logic [127:0] pa, pb, pc, iv2;
  int acc, lastpop;

  initial begin
    reset = 1'b1; cfg_load = 1'b0; mode = 2'd0; iv_in = '0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    eng_done = 1'b0; eng_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_word", out_word, '0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_block", eng_block, '0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ECB single block, latency checks
    clr();
    pa = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send_blk(pa);
    acc = cyc;
    wait_out(4);
    check("ecb_start_cyc", st_cyc[0], acc);
    check("ecb_eng_blk", st_blk[0], pa);
    check("ecb_out", blk_out(0), 128'hFFEEDDCC_BBAA9988_77665544_33221100);
    check("ecb_out_cyc", oc[0], dn_cyc[0] + 1);

    // CBC chaining
    clr();
    cfg(2'd1, IV_CBC);
    send_blk('0);
    send_blk('0);
    wait_out(8);
    check("cbc_blk0", st_blk[0], {16{8'h01}});
    check("cbc_blk1", st_blk[1], {16{8'hFE}});
    check("cbc_out0", blk_out(0), {16{8'hFE}});
    check("cbc_out1", blk_out(1), {16{8'h01}});

    // CTR with low-field wrap
    clr();
    cfg(2'd2, IV_CTR);
    pa = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    pb = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    send_blk(pa);
    send_blk(pb);
    wait_out(8);
    check("ctr_blk0", st_blk[0], IV_CTR);
    check("ctr_blk1", st_blk[1], {{12{8'hA5}}, 32'h0});
    check("ctr_out0", blk_out(0), pa ^ ~IV_CTR);
    check("ctr_out1", blk_out(1), pb ^ ~{{12{8'hA5}}, 32'h0});

    // FIFO backpressure
    clr();
    cfg(2'd0, '0);
    out_ready = 1'b0;
    pa = {4{32'h1111_1111}};
    pb = {4{32'h2222_2222}};
    pc = {4{32'h3333_3333}};
    send_blk(pa);
    send_blk(pb);
    send_blk(pc);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_starts", st_blk.size(), 2);
    check("bp_hold_start", eng_start, 1'b0);
    check("bp_hold_busy", busy, 1'b1);
    check("bp_hold_inrdy", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out(4);
    out_ready = 1'b0;
    lastpop = oc[3];
    wait_start(3);
    check("bp_resume_cyc", st_cyc[2], lastpop + 1);
    out_ready = 1'b1;
    wait_out(12);
    check("bp_out0", blk_out(0), ~pa);
    check("bp_out1", blk_out(1), ~pb);
    check("bp_out2", blk_out(2), ~pc);

    // cfg_load mid-block ignored, at boundary honoured
    clr();
    pa = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    send_word(pa[127:96]);
    send_word(pa[95:64]);
    cfg(2'd2, {4{32'h5555_5555}});
    send_word(pa[63:32]);
    send_word(pa[31:0]);
    wait_out(4);
    check("cfgmid_blk", st_blk[0], pa);
    check("cfgmid_out", blk_out(0), ~pa);
    iv2 = 128'h89ABCDEF_01234567_76543210_FEDCBA98;
    pb = 128'h00000000_FFFFFFFF_12121212_34343434;
    cfg(2'd1, iv2);
    send_blk(pb);
    wait_out(8);
    check("cfgbnd_blk", st_blk[1], pb ^ iv2);
    check("cfgbnd_out", blk_out(1), ~(pb ^ iv2));

    // Reset mid-RUN
    clr();
    send_blk(128'hCAFEBABE_DEADBEEF_01010101_02020202);
    wait_start(1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rr_out_valid", out_valid, 1'b0);
    check("rr_in_ready", in_ready, 1'b1);
    check("rr_busy", busy, 1'b0);
    check("rr_no_push", ow.size(), 0);
    @(posedge clk); #1;
    pa = 128'h10203040_50607080_90A0B0C0_D0E0F000;
    pb = 128'h0A0B0C0D_0E0F1011_12131415_16171819;
    send_blk(pa);
    send_blk(pb);
    wait_out(8);
    check("rr_ecb_blk0", st_blk[1], pa);
    check("rr_ecb_blk1", st_blk[2], pb);
    check("rr_out0", blk_out(0), ~pa);
    check("rr_out1", blk_out(1), ~pb);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
